// File: rtl/instruction_fetch_stage.sv
// Fetch stage: owns the PC, drives instruction memory and fills IF/ID.
// Supports stall, redirect with flush, and a sticky halt.
module instruction_fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
   parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Stall,
   input  logic        Redirect,
   input  logic [31:0] RedirectTarget,
   input  logic [31:0] Instruction,
   output logic [31:0] InstrAddress,
   output logic [31:0] IfId_Instruction,
   output logic [31:0] IfId_PCPlus4,
   output logic        IfId_Valid,
   output logic        Halted,
   output logic [31:0] FetchCount
);

   localparam logic [0:0] ST_RUN    = 1'b0;
   localparam logic [0:0] ST_HALTED = 1'b1;

   logic [0:0]  state;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [31:0] target_aligned;

   assign pc_plus4       = pc + 32'd4;
   assign target_aligned = {RedirectTarget[31:2], 2'b00};
   assign InstrAddress   = pc;
   assign Halted         = (state == ST_HALTED);

   // PC, IF/ID register, fetch counter and run/halt state
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state            <= ST_RUN;
         pc               <= RESET_PC;
         IfId_Instruction <= NOP_WORD;
         IfId_PCPlus4     <= 32'd0;
         IfId_Valid       <= 1'b0;
         FetchCount       <= 32'd0;
      end else if (state == ST_HALTED) begin
         // PC and count frozen; IF/ID drains to a bubble and stays there
         IfId_Instruction <= NOP_WORD;
         IfId_PCPlus4     <= 32'd0;
         IfId_Valid       <= 1'b0;
      end else if (Redirect) begin
         // redirect outranks stall so a taken branch is never lost
         pc               <= target_aligned;
         IfId_Instruction <= NOP_WORD;
         IfId_PCPlus4     <= 32'd0;
         IfId_Valid       <= 1'b0;
      end else if (!Stall) begin
         pc               <= pc_plus4;
         IfId_Instruction <= Instruction;
         IfId_PCPlus4     <= pc_plus4;
         IfId_Valid       <= 1'b1;
         FetchCount       <= FetchCount + 32'd1;
         if (Instruction == HALT_WORD) begin
            state <= ST_HALTED;
         end
      end
   end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: directed plan plus random traffic.
// Expected state comes from a spec-level model through a scoreboard queue.
module tb_instruction_fetch_stage;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        Stall = 1'b0;
   logic        Redirect = 1'b0;
   logic [31:0] RedirectTarget = 32'd0;
   logic [31:0] Instruction;
   logic [31:0] InstrAddress;
   logic [31:0] IfId_Instruction;
   logic [31:0] IfId_PCPlus4;
   logic        IfId_Valid;
   logic        Halted;
   logic [31:0] FetchCount;

   instruction_fetch_stage dut (
      .Clk              (Clk),
      .Reset            (Reset),
      .Stall            (Stall),
      .Redirect         (Redirect),
      .RedirectTarget   (RedirectTarget),
      .Instruction      (Instruction),
      .InstrAddress     (InstrAddress),
      .IfId_Instruction (IfId_Instruction),
      .IfId_PCPlus4     (IfId_PCPlus4),
      .IfId_Valid       (IfId_Valid),
      .Halted           (Halted),
      .FetchCount       (FetchCount)
   );

   always #5 Clk = ~Clk;

   // memory image: 64 words indexed by address bits [7:2], plus one halt slot
   logic [31:0] mem [64];
   logic        halt_en = 1'b0;
   logic [31:0] halt_addr = 32'd0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (halt_en && a == halt_addr) return 32'hFFFF_FFFF;
      return mem[a[7:2]];
   endfunction

   always_comb Instruction = mem_word(InstrAddress);

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ii;
      logic [31:0] ip;
      logic        iv;
      logic        halted;
      logic [31:0] cnt;
   } snap_t;

   snap_t exp_q[$];
   snap_t m;
   int checks = 0;
   int fails  = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // reference model: one clock edge of the fetch stage described by its rules
   task automatic model_edge(input logic rst, input logic stl,
                             input logic rdr, input logic [31:0] tgt);
      logic [31:0] w;
      if (!rst) begin
         m.pc = 32'd0; m.ii = 32'd0; m.ip = 32'd0; m.iv = 1'b0;
         m.halted = 1'b0; m.cnt = 32'd0;
      end else if (m.halted) begin
         m.ii = 32'd0; m.ip = 32'd0; m.iv = 1'b0;
      end else if (rdr) begin
         m.pc = tgt - (tgt % 4);
         m.ii = 32'd0; m.ip = 32'd0; m.iv = 1'b0;
      end else if (!stl) begin
         w = mem_word(m.pc);
         m.ii = w;
         m.ip = 32'((64'(m.pc) + 64'd4) % 64'h1_0000_0000);
         m.iv = 1'b1;
         m.cnt = m.cnt + 32'd1;
         m.pc = m.ip;
         if (w == 32'hFFFF_FFFF) m.halted = 1'b1;
      end
   endtask

   task automatic step(input logic rst, input logic stl,
                       input logic rdr, input logic [31:0] tgt);
      @(negedge Clk);
      Reset = rst; Stall = stl; Redirect = rdr; RedirectTarget = tgt;
      model_edge(rst, stl, rdr, tgt);
      exp_q.push_back(m);
      @(posedge Clk);
      #3;
   endtask

   // monitor: every edge the stage presents a new state; compare it
   always @(posedge Clk) begin
      snap_t e;
      #2;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("pc", InstrAddress, e.pc);
         check("ifid_instr", IfId_Instruction, e.ii);
         check("ifid_pc4", IfId_PCPlus4, e.ip);
         check("ifid_valid", 32'(IfId_Valid), 32'(e.iv));
         check("halted", 32'(Halted), 32'(e.halted));
         check("fetch_count", FetchCount, e.cnt);
      end
   end

   initial begin
      logic r, s, d;
      logic [31:0] t;
      for (int i = 0; i < 64; i++) mem[i] = 32'(i * 3);
      m = '{default: '0};

      // reset then run
      step(1'b0, 1'b0, 1'b0, 32'd0);
      step(1'b0, 1'b0, 1'b0, 32'd0);
      check("reset_valid", 32'(IfId_Valid), 32'd0);
      check("reset_pc", InstrAddress, 32'd0);
      step(1'b1, 1'b0, 1'b0, 32'd0);
      check("e1_instr", IfId_Instruction, 32'd0);
      check("e1_pc4", IfId_PCPlus4, 32'd4);
      check("e1_valid", 32'(IfId_Valid), 32'd1);
      step(1'b1, 1'b0, 1'b0, 32'd0);
      check("e2_instr", IfId_Instruction, 32'd3);
      check("e2_pc4", IfId_PCPlus4, 32'd8);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'd0);
      check("run_count", FetchCount, 32'd5);
      check("run_addr", InstrAddress, 32'd20);

      // stall at PC=12
      step(1'b0, 1'b0, 1'b0, 32'd0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'd0);
      check("pre_stall_pc", InstrAddress, 32'd12);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b1, 1'b0, 32'd0);
         check("stall_pc", InstrAddress, 32'd12);
         check("stall_instr", IfId_Instruction, 32'd6);
         check("stall_count", FetchCount, 32'd3);
      end
      step(1'b1, 1'b0, 1'b0, 32'd0);
      check("release_instr", IfId_Instruction, 32'd9);
      check("release_pc", InstrAddress, 32'd16);

      // redirect beats stall, target low bits dropped
      step(1'b1, 1'b1, 1'b1, 32'h0000_0043);
      check("redir_pc", InstrAddress, 32'h40);
      check("redir_valid", 32'(IfId_Valid), 32'd0);
      check("redir_instr", IfId_Instruction, 32'd0);
      check("redir_count", FetchCount, 32'd4);
      step(1'b1, 1'b0, 1'b0, 32'd0);
      check("post_redir_instr", IfId_Instruction, 32'd48);
      check("post_redir_pc4", IfId_PCPlus4, 32'h44);

      // halt word at 0x10
      halt_en = 1'b1; halt_addr = 32'h10;
      step(1'b0, 1'b0, 1'b0, 32'd0);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 32'd0);
      check("halt_flag", 32'(Halted), 32'd1);
      check("halt_valid", 32'(IfId_Valid), 32'd1);
      check("halt_count", FetchCount, 32'd5);
      step(1'b1, 1'b0, 1'b0, 32'd0);
      check("halt_bubble", 32'(IfId_Valid), 32'd0);
      step(1'b1, 1'b0, 1'b1, 32'h100);
      step(1'b1, 1'b1, 1'b0, 32'd0);
      check("halt_pc", InstrAddress, 32'h14);

      // reset while halted, then reset under stall+redirect
      step(1'b0, 1'b0, 1'b1, 32'h80);
      check("rst_halt_pc", InstrAddress, 32'd0);
      check("rst_halt_flag", 32'(Halted), 32'd0);
      check("rst_halt_count", FetchCount, 32'd0);
      halt_en = 1'b0;
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'd0);
      step(1'b0, 1'b1, 1'b1, 32'h80);
      check("rst_sr_pc", InstrAddress, 32'd0);
      check("rst_sr_count", FetchCount, 32'd0);
      check("rst_sr_valid", 32'(IfId_Valid), 32'd0);

      // wrap at top of address space
      step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
      step(1'b1, 1'b0, 1'b0, 32'd0);
      check("wrap_pc", InstrAddress, 32'd0);
      check("wrap_pc4", IfId_PCPlus4, 32'd0);

      // random traffic
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 49) == 0) begin
            halt_en = $urandom_range(0, 1) == 1;
            halt_addr = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
         end
         r = $urandom_range(0, 39) != 0;
         s = $urandom_range(0, 3) == 0;
         d = $urandom_range(0, 7) == 0;
         t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                         : 32'($urandom_range(0, 511));
         step(r, s, d, t);
      end

      @(negedge Clk);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
